// File: rtl/alu_scheduler.sv
// alu_scheduler: round-robin arbiter that lets two clients share one registered-input ALU
// IDLE accepts a request, EXEC captures the ALU result, RESP returns it to the owner.
module alu_scheduler #(
    parameter int BW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [2:0]    req0_op,
    input  logic [BW-1:0] req0_a,
    input  logic [BW-1:0] req0_b,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [2:0]    req1_op,
    input  logic [BW-1:0] req1_a,
    input  logic [BW-1:0] req1_b,
    output logic          resp0_valid,
    input  logic          resp0_ready,
    output logic [BW-1:0] resp0_out,
    output logic [2:0]    resp0_flags,
    output logic          resp1_valid,
    input  logic          resp1_ready,
    output logic [BW-1:0] resp1_out,
    output logic [2:0]    resp1_flags,
    output logic [BW-1:0] alu_a,
    output logic [BW-1:0] alu_b,
    output logic [2:0]    alu_op,
    input  logic [BW-1:0] alu_out,
    input  logic [2:0]    alu_flags,
    output logic          busy,
    output logic [7:0]    ovf_cnt
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t        state_q, state_d;
    logic          last_q, last_d, owner_q, owner_d;
    logic [2:0]    op_q, op_d, flg_q, flg_d;
    logic [BW-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [7:0]    ovf_q, ovf_d;
    logic          idle, win1, accept, resp_hs;

    assign idle = state_q == IDLE;
    // On a tie the requester that was not served last wins
    assign win1 = req1_valid && (!req0_valid || !last_q);
    assign req0_ready = idle && req0_valid && !win1;
    assign req1_ready = idle && win1;
    assign accept = req0_ready || req1_ready;
    assign resp_hs = state_q == RESP && (owner_q ? resp1_ready : resp0_ready);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        flg_d   = flg_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d = EXEC;
                owner_d = win1;
                op_d    = win1 ? req1_op : req0_op;
                a_d     = win1 ? req1_a : req0_a;
                b_d     = win1 ? req1_b : req0_b;
            end
            EXEC: begin
                state_d = RESP;
                res_d   = alu_out;
                flg_d   = alu_flags;
                ovf_d   = ovf_q + 8'(alu_flags[2] && ovf_q != 8'hFF);
            end
            RESP: if (resp_hs) begin
                state_d = IDLE;
                last_d  = owner_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            flg_q   <= '0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy        = !idle;
    assign resp0_valid = state_q == RESP && !owner_q;
    assign resp1_valid = state_q == RESP && owner_q;
    assign resp0_out   = resp0_valid ? res_q : '0;
    assign resp1_out   = resp1_valid ? res_q : '0;
    assign resp0_flags = resp0_valid ? flg_q : '0;
    assign resp1_flags = resp1_valid ? flg_q : '0;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_op      = op_q;
    assign ovf_cnt     = ovf_q;
endmodule

// File: tb/tb_alu_scheduler.sv
// tb_alu_scheduler: directed table, random transactions and reset corner cases for alu_scheduler
// The bench supplies the shared ALU itself and predicts results, arbitration and ovf_cnt per transaction.
module tb_alu_scheduler;
    logic        clk = 1'b0, rst = 1'b1;
    logic [1:0]  rv, rdy, pv, pr;
    logic [2:0]  rop [2];
    logic [15:0] ra [2], rb [2], pout [2];
    logic [2:0]  pfl [2];
    logic [15:0] alu_a, alu_b, alu_out;
    logic [2:0]  alu_op, alu_flags;
    logic        busy;
    logic [7:0]  ovf_cnt;
    int          checks = 0, errors = 0, exp_ovf = 0, last_m = 1;

    typedef struct {
        logic [1:0]  mask;
        logic [2:0]  op;
        logic [15:0] a, b, out;
        logic [2:0]  fl;
        int          hold;
    } vec_t;
    vec_t tbl [11];

    always #5 clk = ~clk;

    alu_scheduler #(.BW(16)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(rv[0]), .req0_ready(rdy[0]), .req0_op(rop[0]), .req0_a(ra[0]), .req0_b(rb[0]),
        .req1_valid(rv[1]), .req1_ready(rdy[1]), .req1_op(rop[1]), .req1_a(ra[1]), .req1_b(rb[1]),
        .resp0_valid(pv[0]), .resp0_ready(pr[0]), .resp0_out(pout[0]), .resp0_flags(pfl[0]),
        .resp1_valid(pv[1]), .resp1_ready(pr[1]), .resp1_out(pout[1]), .resp1_flags(pfl[1]),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out), .alu_flags(alu_flags),
        .busy(busy), .ovf_cnt(ovf_cnt)
    );

    // Returns {overflow, negative, zero, result}
    function automatic logic [18:0] alu_f(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        logic v;
        v = 1'b0;
        case (op)
            3'd0: begin r = a + b; v = (a[15] == b[15]) && (r[15] != a[15]); end
            3'd1: begin r = a - b; v = (a[15] != b[15]) && (r[15] != a[15]); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: begin r = a + 16'd1; v = (a == 16'h7FFF); end
            3'd6: r = a;
            default: r = b;
        endcase
        return {v, r[15], r == 16'h0, r};
    endfunction

    always_comb {alu_flags, alu_out} = alu_f(alu_op, alu_a, alu_b);

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 3))
            0: return 16'h7FFF;
            1: return 16'h8000;
            2: return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // One full transaction, entered and left just after a rising edge with the DUT idle
    task automatic txn(input logic [1:0] mask, input int hold, output logic [15:0] out, output logic [2:0] fl);
        int w, n;
        logic [18:0] e;
        w = (mask == 2'b11) ? (last_m == 1 ? 0 : 1) : (mask == 2'b01 ? 0 : 1);
        rv = mask;
        pr = '0;
        pr[1-w] = 1'b1;
        pr[w] = (hold == 0);
        @(negedge clk);
        chk("ready", rdy, 64'(1 << w));
        @(posedge clk);
        #1 rv[w] = 1'b0;
        e = alu_f(rop[w], ra[w], rb[w]);
        if (e[18] && exp_ovf < 255) exp_ovf++;
        @(negedge clk);
        chk("busy", busy, 1);
        chk("alu_in", {alu_op, alu_a, alu_b}, {rop[w], ra[w], rb[w]});
        chk("resp_exec", pv, 0);
        n = 1;
        while (pv[w] !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, 2);
        chk("resp_valid", pv, 64'(1 << w));
        chk("resp_out", pout[w], e[15:0]);
        chk("resp_flags", pfl[w], e[18:16]);
        chk("other_resp", {pout[1-w], pfl[1-w]}, 0);
        chk("ovf_cnt", ovf_cnt, exp_ovf);
        out = pout[w];
        fl = pfl[w];
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_out", {pfl[w], pout[w]}, e);
            chk("hold_valid_ready", {pv, rdy}, 64'(4 << w));
        end
        pr[w] = 1'b1;
        @(posedge clk);
        #1 pr = '0;
        last_m = w;
        chk("back_idle", {busy, pv}, 0);
    endtask

    initial begin
        logic [15:0] o, sav;
        logic [2:0] f;
        rv = '0;
        pr = '0;
        for (int s = 0; s < 2; s++) begin rop[s] = '0; ra[s] = '0; rb[s] = '0; end
        tbl[0]  = '{2'b11, 3'd1, 16'd5,     16'd5,     16'h0000, 3'b001, 0};
        tbl[1]  = '{2'b10, 3'd2, 16'h00F0,  16'h0FF0,  16'h00F0, 3'b000, 0};
        tbl[2]  = '{2'b11, 3'd0, 16'd100,   16'd23,    16'd123,  3'b000, 0};
        tbl[3]  = '{2'b10, 3'd0, 16'h7FFF,  16'h0001,  16'h8000, 3'b110, 0};
        tbl[4]  = '{2'b11, 3'd7, 16'h0001,  16'hFFF9,  16'hFFF9, 3'b010, 5};
        tbl[5]  = '{2'b10, 3'd4, 16'hFF00,  16'h0F0F,  16'hF00F, 3'b010, 0};
        tbl[6]  = '{2'b01, 3'd5, 16'h7FFF,  16'h1111,  16'h8000, 3'b110, 2};
        tbl[7]  = '{2'b10, 3'd3, 16'h1234,  16'h4321,  16'h5335, 3'b000, 1};
        tbl[8]  = '{2'b01, 3'd6, 16'h0000,  16'hABCD,  16'h0000, 3'b001, 0};
        tbl[9]  = '{2'b10, 3'd5, 16'hFFFF,  16'h0000,  16'h0000, 3'b001, 3};
        tbl[10] = '{2'b01, 3'd1, 16'h8000,  16'h0001,  16'h7FFF, 3'b100, 0};
        #1 chk("rst_during", {busy, rdy, pv, ovf_cnt, alu_op, alu_a, alu_b, pout[0], pout[1]}, 0);
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        chk("rst_idle", {busy, rdy, pv, ovf_cnt, alu_op, alu_a, alu_b, pfl[0], pfl[1]}, 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 11; i++) begin
            for (int s = 0; s < 2; s++)
                if (tbl[i].mask[s]) begin rop[s] = tbl[i].op; ra[s] = tbl[i].a; rb[s] = tbl[i].b; end
            txn(tbl[i].mask, tbl[i].hold, o, f);
            chk("tbl_out", o, tbl[i].out);
            chk("tbl_flags", f, tbl[i].fl);
        end
        for (int i = 0; i < 150; i++) begin
            for (int s = 0; s < 2; s++) begin rop[s] = 3'($urandom_range(0, 7)); ra[s] = pick(); rb[s] = pick(); end
            txn(2'($urandom_range(1, 3)), $urandom_range(0, 3), o, f);
        end
        sav = alu_a;
        rv = 2'b11;
        @(negedge clk);
        chk("tie_ready", rdy, last_m == 1 ? 64'd1 : 64'd2);
        rv = '0;
        @(posedge clk);
        #1 chk("dropped_not_accepted", {busy, alu_a}, {1'b0, sav});
        rop[1] = 3'd0; ra[1] = 16'h7FFF; rb[1] = 16'h0001;
        repeat (260) txn(2'b10, 0, o, f);
        chk("ovf_saturated", ovf_cnt, 255);
        rop[0] = 3'd0; ra[0] = 16'h7FFF; rb[0] = 16'h7FFF;
        rv = 2'b01;
        pr = 2'b11;
        @(negedge clk);
        chk("pre_rst_ready", rdy, 1);
        @(posedge clk);
        #1 rv = '0;
        @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1 chk("rst_abort", {busy, rdy, pv, ovf_cnt, alu_op, alu_a, alu_b, pout[0], pfl[0]}, 0);
        @(negedge clk) rst = 1'b0;
        exp_ovf = 0;
        last_m = 1;
        pr = '0;
        @(negedge clk);
        chk("rst_no_resp", {busy, pv, ovf_cnt}, 0);
        rv = 2'b11;
        #1 chk("rst_last", rdy, 1);
        rv = '0;
        @(posedge clk);
        #1 txn(2'b01, 0, o, f);
        chk("post_rst_out", {f, o}, {3'b110, 16'hFFFE});
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
